prbs32_checker: RTL and testbench

Receive-side companion to the 32-bit PRBS generator. It checks a serial bit stream produced by the polynomial x^32 + x^22 + x^2 + x + 1, with the generator's bit-0 output taken as the stream bit. The checker self-synchronises from received bits, declares lock, counts bit mismatches and checked bits, and drops lock on burst errors or a stuck-zero stream. It sits behind the pad-input path, in the user project next to the generator, for loopback and off-chip link testing.

---
 rtl/prbs32_checker.sv | 174 +++++++++++++++++
 tb/tb_prbs32_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs32_checker.sv
// ---------------------------------------------------------------------------
// prbs32_checker - self-synchronising checker for the x^32+x^22+x^2+x+1 PRBS
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prbs32_checker #(
  parameter int LOCK_CNT  = 64,
  parameter int LOSS_ERRS = 8,
  parameter int LOSS_WIN  = 256,
  parameter int ERR_W     = 16,
  parameter int BIT_W     = 32
) (
  input  logic             Clk,
  input  logic             Rstb,
  input  logic             En,
  input  logic             DataIn,
  input  logic             ClrCnt,
  output logic             Locked,
  output logic             ErrPulse,
  output logic [ERR_W-1:0] ErrCnt,
  output logic [BIT_W-1:0] BitCnt,
  output logic             LockLost
);

  localparam int               WIN_W       = $clog2(LOSS_WIN + 1);
  localparam logic [7:0]       C_LOCK_CNT  = 8'(LOCK_CNT);
  localparam logic [7:0]       C_FILL_LAST = 8'd31;
  localparam logic [WIN_W-1:0] C_LOSS_ERRS = WIN_W'(LOSS_ERRS);
  localparam logic [WIN_W-1:0] C_LOSS_WIN  = WIN_W'(LOSS_WIN);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        hist_q, hist_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_bits_q, win_bits_d;
  logic [WIN_W-1:0]   win_errs_q, win_errs_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic               lock_lost_q, lock_lost_d;

  logic [31:0]        hist_shift;
  logic               predict;
  logic               mismatch;
  logic [7:0]         cnt_inc;
  logic [WIN_W-1:0]   win_bits_inc;
  logic [WIN_W-1:0]   win_errs_inc;
  logic [ERR_W-1:0]   err_cnt_inc;
  logic [BIT_W-1:0]   bit_cnt_inc;
  logic               count_bit;
  logic               count_err;
  logic               lost_set;

  assign hist_shift   = {hist_q[30:0], DataIn};
  assign predict      = hist_q[0] ^ hist_q[1] ^ hist_q[21] ^ hist_q[31];
  assign mismatch     = DataIn ^ predict;
  // The good-count sticks at LOCK_CNT so a zero history delays lock rather than restarting the count.
  assign cnt_inc      = (cnt_q == C_LOCK_CNT) ? cnt_q : cnt_q + 8'd1;
  assign win_bits_inc = win_bits_q + 1'b1;
  assign win_errs_inc = win_errs_q + WIN_W'(mismatch);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_pulse_d = 1'b0;
    count_bit   = 1'b0;
    count_err   = 1'b0;
    lost_set    = 1'b0;

    if (En) begin
      hist_d = hist_shift;
      case (state_q)
        ST_FILL: begin
          if (cnt_q == C_FILL_LAST) begin
            state_d = ST_HUNT;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_HUNT: begin
          if (mismatch) begin
            cnt_d = 8'd0;
          end else begin
            cnt_d = cnt_inc;
            if ((cnt_inc == C_LOCK_CNT) && (hist_shift != 32'd0)) begin
              state_d    = ST_LOCKED;
              win_bits_d = '0;
              win_errs_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          count_bit   = 1'b1;
          count_err   = mismatch;
          err_pulse_d = mismatch;
          win_bits_d  = win_bits_inc;
          win_errs_d  = win_errs_inc;
          // Burst and stuck-zero loss take priority over the window rollover.
          if ((win_errs_inc == C_LOSS_ERRS) || (hist_shift == 32'd0)) begin
            state_d  = ST_HUNT;
            cnt_d    = 8'd0;
            lost_set = 1'b1;
          end else if (win_bits_inc == C_LOSS_WIN) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end
        end
        default: begin
          state_d = ST_FILL;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_inc = err_cnt_q;
    bit_cnt_inc = bit_cnt_q;
    if (count_err && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_inc = err_cnt_q + 1'b1;
    if (count_bit && (bit_cnt_q != {BIT_W{1'b1}})) bit_cnt_inc = bit_cnt_q + 1'b1;

    // A clear coinciding with an event keeps that event's count.
    err_cnt_d   = ClrCnt ? ERR_W'(count_err) : err_cnt_inc;
    bit_cnt_d   = ClrCnt ? BIT_W'(count_bit) : bit_cnt_inc;
    lock_lost_d = lost_set | (lock_lost_q & ~ClrCnt);
    locked_d    = (state_d == ST_LOCKED);
  end

  always_ff @(posedge Clk) begin
    if (!Rstb) begin
      state_q     <= ST_FILL;
      hist_q      <= 32'd0;
      cnt_q       <= 8'd0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign Locked   = locked_q;
  assign ErrPulse = err_pulse_q;
  assign ErrCnt   = err_cnt_q;
  assign BitCnt   = bit_cnt_q;
  assign LockLost = lock_lost_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs32_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs32_checker - directed vector bench for prbs32_checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prbs32_checker;

  logic        Clk = 1'b0;
  logic        Rstb;
  logic        En;
  logic        DataIn;
  logic        ClrCnt;
  logic        Locked;
  logic        ErrPulse;
  logic [15:0] ErrCnt;
  logic [31:0] BitCnt;
  logic        LockLost;

  prbs32_checker #(
    .LOCK_CNT (64),
    .LOSS_ERRS(8),
    .LOSS_WIN (256),
    .ERR_W    (16),
    .BIT_W    (32)
  ) dut (
    .Clk     (Clk),
    .Rstb    (Rstb),
    .En      (En),
    .DataIn  (DataIn),
    .ClrCnt  (ClrCnt),
    .Locked  (Locked),
    .ErrPulse(ErrPulse),
    .ErrCnt  (ErrCnt),
    .BitCnt  (BitCnt),
    .LockLost(LockLost)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          nbits;
    int          nflip;
    logic        exp_locked;
    int          exp_err;
    int          exp_bits;
    logic        exp_ll;
    int          exp_npulse;
    logic [63:0] exp_mask;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] gen;
  int          errors = 0;
  int          checks = 0;
  int          step_idx;
  int          npulse;
  logic [63:0] pmask;
  logic        pulse_on_idle;
  logic        idle_change;
  logic        seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Generator model: output is state bit 0, new bit shifts in at the bottom.
  task automatic tick(input logic en, input logic flip, input logic zero, input logic clr);
    logic prev_locked;
    prev_locked = Locked;
    En     = en;
    DataIn = zero ? 1'b0 : (gen[0] ^ flip);
    ClrCnt = clr;
    @(posedge Clk);
    #1;
    if (en) gen = {gen[30:0], gen[31] ^ gen[21] ^ gen[1] ^ gen[0]};
    if (ErrPulse) begin
      npulse++;
      if (step_idx < 64) pmask[step_idx] = 1'b1;
      if (!en) pulse_on_idle = 1'b1;
    end
    if (!en && (Locked !== prev_locked)) idle_change = 1'b1;
    step_idx++;
  endtask

  task automatic do_reset();
    Rstb   = 1'b0;
    En     = 1'b1;
    DataIn = ~gen[0];
    ClrCnt = 1'b1;
    @(posedge Clk);
    #1;
    Rstb   = 1'b1;
    ClrCnt = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " Locked"},   64'(Locked),   64'd0);
    check({tag, " ErrPulse"}, 64'(ErrPulse), 64'd0);
    check({tag, " ErrCnt"},   64'(ErrCnt),   64'd0);
    check({tag, " BitCnt"},   64'(BitCnt),   64'd0);
    check({tag, " LockLost"}, 64'(LockLost), 64'd0);
  endtask

  initial begin
    // Stream from seed 1: lock at valid bit 96, then single error, window
    // rollover, 8-bit burst loss and relock 64 good bits after the last echo.
    vecs[0] = '{95,  0, 1'b0, 0,  0,   1'b0, 0, 64'h0};
    vecs[1] = '{1,   0, 1'b1, 0,  0,   1'b0, 0, 64'h0};
    vecs[2] = '{50,  0, 1'b1, 0,  50,  1'b0, 0, 64'h0};
    vecs[3] = '{40,  1, 1'b1, 5,  90,  1'b0, 5, 64'h0000_0001_0040_0007};
    vecs[4] = '{166, 0, 1'b1, 5,  256, 1'b0, 0, 64'h0};
    vecs[5] = '{10,  8, 1'b0, 13, 266, 1'b1, 8, 64'h0000_0000_0000_02FD};
    vecs[6] = '{93,  0, 1'b0, 13, 266, 1'b1, 0, 64'h0};
    vecs[7] = '{1,   0, 1'b1, 13, 266, 1'b1, 0, 64'h0};

    gen           = 32'd1;
    pulse_on_idle = 1'b0;
    idle_change   = 1'b0;
    step_idx      = 0;
    npulse        = 0;
    pmask         = '0;
    do_reset();
    do_reset();
    check_all_zero("reset");

    for (int v = 0; v < 8; v++) begin
      step_idx = 0;
      npulse   = 0;
      pmask    = '0;
      for (int i = 0; i < vecs[v].nbits; i++) tick(1'b1, i < vecs[v].nflip, 1'b0, 1'b0);
      check($sformatf("v%0d Locked", v),   64'(Locked),   64'(vecs[v].exp_locked));
      check($sformatf("v%0d ErrCnt", v),   64'(ErrCnt),   64'(vecs[v].exp_err));
      check($sformatf("v%0d BitCnt", v),   64'(BitCnt),   64'(vecs[v].exp_bits));
      check($sformatf("v%0d LockLost", v), 64'(LockLost), 64'(vecs[v].exp_ll));
      check($sformatf("v%0d pulses", v),   64'(npulse),   64'(vecs[v].exp_npulse));
      check($sformatf("v%0d pulse_offs", v), pmask,       vecs[v].exp_mask);
    end

    // Clear with a checked bit, then clear with a mismatch.
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("clr ErrCnt",   64'(ErrCnt),   64'd0);
    check("clr BitCnt",   64'(BitCnt),   64'd1);
    check("clr LockLost", 64'(LockLost), 64'd0);
    check("clr Locked",   64'(Locked),   64'd1);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr+err ErrCnt",   64'(ErrCnt),   64'd1);
    check("clr+err BitCnt",   64'(BitCnt),   64'd1);
    check("clr+err ErrPulse", 64'(ErrPulse), 64'd1);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("echo ErrCnt", 64'(ErrCnt), 64'd5);
    check("echo BitCnt", 64'(BitCnt), 64'd41);
    check("echo Locked", 64'(Locked), 64'd1);

    // Stuck-zero line.
    for (int i = 0; i < 32; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("zero Locked",   64'(Locked),   64'd0);
    check("zero LockLost", 64'(LockLost), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      if (Locked) seen = 1'b1;
    end
    check("zero no relock", 64'(seen), 64'd0);

    do_reset();
    check_all_zero("reset2");

    // En toggling: idle cycles carry the inverted next bit and must be ignored.
    gen           = 32'd1;
    npulse        = 0;
    pulse_on_idle = 1'b0;
    idle_change   = 1'b0;
    seen          = 1'b0;
    for (int k = 1; k <= 96; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (k < 96) begin
        if (Locked) seen = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    check("toggle early lock", 64'(seen),   64'd0);
    check("toggle Locked@96",  64'(Locked), 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("toggle BitCnt",      64'(BitCnt),        64'd20);
    check("toggle pulses",      64'(npulse),        64'd0);
    check("toggle idle pulse",  64'(pulse_on_idle), 64'd0);
    check("toggle idle change", 64'(idle_change),   64'd0);

    // Reset mid-lock, then FILL must restart on the continuing stream.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("midlock ErrCnt", 64'(ErrCnt), 64'd1);
    do_reset();
    check_all_zero("midlock reset");
    for (int k = 1; k <= 96; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 95) check("refill Locked@95", 64'(Locked), 64'd0);
    end
    check("refill Locked@96", 64'(Locked),   64'd1);
    check("refill ErrCnt",    64'(ErrCnt),   64'd0);
    check("refill LockLost",  64'(LockLost), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
